// File: rtl/msrv32_agu_pipe_if.sv
// Request/response bundle between the operand-fetch stage, the address
// generation unit and its consumer (branch unit / LSU).
//   Request side : in_valid_in, in_ready_out, mode_in, size_in, pc_in, rs1_in, imm_in
//   Response side: out_valid_out, out_ready_in, iadder_out, misalign_out, carry_out
// The master modport is the environment (producer and consumer), and the
// slave modport is the AGU itself.
interface msrv32_agu_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid_in;
    logic            in_ready_out;
    logic [1:0]      mode_in;
    logic [1:0]      size_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] imm_in;
    logic            out_valid_out;
    logic            out_ready_in;
    logic [XLEN-1:0] iadder_out;
    logic            misalign_out;
    logic            carry_out;

    modport master (
        output in_valid_in, mode_in, size_in, pc_in, rs1_in, imm_in, out_ready_in,
        input  in_ready_out, out_valid_out, iadder_out, misalign_out, carry_out
    );

    modport slave (
        input  in_valid_in, mode_in, size_in, pc_in, rs1_in, imm_in, out_ready_in,
        output in_ready_out, out_valid_out, iadder_out, misalign_out, carry_out
    );
endinterface

// File: rtl/msrv32_agu_pipe.sv
// Registered address-generation unit with a 2-entry valid/ready skid queue.
// It computes PC+imm, RS1+imm, (RS1+imm)&~1 (JALR) or PC+4. It flags a
// misaligned result for the requested access size and returns the unsigned
// carry of the add.
// Ports:
//   ms_riscv32_mp_clk_in : clock, rising edge
//   ms_riscv32_mp_rst_in : asynchronous active-low reset
//   flush_in             : synchronous flush, empties the queue
//   agu                  : request/response bundle (slave side)
module msrv32_agu_pipe #(
    parameter int XLEN      = 32,
    parameter bit ALIGN_CHK = 1'b1
) (
    input logic              ms_riscv32_mp_clk_in,
    input logic              ms_riscv32_mp_rst_in,
    input logic              flush_in,
    msrv32_agu_pipe_if.slave agu
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    state_e          state_q, state_d;
    logic [XLEN-1:0] head_addr_q, head_addr_d;
    logic            head_mis_q, head_mis_d;
    logic            head_carry_q, head_carry_d;
    logic [XLEN-1:0] tail_addr_q, tail_addr_d;
    logic            tail_mis_q, tail_mis_d;
    logic            tail_carry_q, tail_carry_d;

    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] opnd_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN-1:0] new_addr_s;
    logic            new_mis_s;
    logic            new_carry_s;
    logic            accept_s;
    logic            pop_s;

    // The misalignment check uses the low address bits for the access size.
    // A dword access on a 32-bit core is checked as a word access.
    function automatic logic misalign_f(input logic [XLEN-1:0] addr, input logic [1:0] size);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr[0];
            2'b10:   mis = |addr[1:0];
            2'b11:   mis = (XLEN == 64) ? (|addr[2:0]) : (|addr[1:0]);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Operand selection, add, JALR LSB clear and misalign flag for the incoming request
    always_comb begin
        base_s = agu.pc_in;
        opnd_s = agu.imm_in;
        case (agu.mode_in)
            2'b00:   begin base_s = agu.pc_in;  opnd_s = agu.imm_in; end
            2'b01:   begin base_s = agu.rs1_in; opnd_s = agu.imm_in; end
            2'b10:   begin base_s = agu.rs1_in; opnd_s = agu.imm_in; end
            2'b11:   begin base_s = agu.pc_in;  opnd_s = PC_STEP;    end
            default: begin base_s = agu.pc_in;  opnd_s = agu.imm_in; end
        endcase
        sum_s       = {1'b0, base_s} + {1'b0, opnd_s};
        new_addr_s  = sum_s[XLEN-1:0];
        // JALR clears bit 0 of the address only. The carry still comes from the raw sum.
        if (agu.mode_in == 2'b10) begin
            new_addr_s[0] = 1'b0;
        end else begin
            new_addr_s[0] = sum_s[0];
        end
        new_carry_s = sum_s[XLEN];
        if (ALIGN_CHK) begin
            new_mis_s = misalign_f(new_addr_s, agu.size_in);
        end else begin
            new_mis_s = 1'b0;
        end
    end

    assign agu.in_ready_out  = (state_q != S_FULL);
    assign agu.out_valid_out = (state_q != S_EMPTY);
    assign agu.iadder_out    = head_addr_q;
    assign agu.misalign_out  = head_mis_q;
    assign agu.carry_out     = head_carry_q;

    assign accept_s = agu.in_valid_in & agu.in_ready_out;
    assign pop_s    = agu.out_valid_out & agu.out_ready_in;

    // Queue occupancy FSM and entry movement. A flush overrides accept and pop.
    always_comb begin
        state_d      = state_q;
        head_addr_d  = head_addr_q;
        head_mis_d   = head_mis_q;
        head_carry_d = head_carry_q;
        tail_addr_d  = tail_addr_q;
        tail_mis_d   = tail_mis_q;
        tail_carry_d = tail_carry_q;
        if (flush_in) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_s) begin
                        head_addr_d  = new_addr_s;
                        head_mis_d   = new_mis_s;
                        head_carry_d = new_carry_s;
                        state_d      = S_ONE;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (accept_s && pop_s) begin
                        head_addr_d  = new_addr_s;
                        head_mis_d   = new_mis_s;
                        head_carry_d = new_carry_s;
                        state_d      = S_ONE;
                    end else if (accept_s) begin
                        tail_addr_d  = new_addr_s;
                        tail_mis_d   = new_mis_s;
                        tail_carry_d = new_carry_s;
                        state_d      = S_FULL;
                    end else if (pop_s) begin
                        state_d = S_EMPTY;
                    end else begin
                        state_d = S_ONE;
                    end
                end
                S_FULL: begin
                    if (pop_s) begin
                        head_addr_d  = tail_addr_q;
                        head_mis_d   = tail_mis_q;
                        head_carry_d = tail_carry_q;
                        state_d      = S_ONE;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State and entry registers
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q      <= S_EMPTY;
            head_addr_q  <= {XLEN{1'b0}};
            head_mis_q   <= 1'b0;
            head_carry_q <= 1'b0;
            tail_addr_q  <= {XLEN{1'b0}};
            tail_mis_q   <= 1'b0;
            tail_carry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_addr_q  <= head_addr_d;
            head_mis_q   <= head_mis_d;
            head_carry_q <= head_carry_d;
            tail_addr_q  <= tail_addr_d;
            tail_mis_q   <= tail_mis_d;
            tail_carry_q <= tail_carry_d;
        end
    end

endmodule

// File: tb/tb_msrv32_agu_pipe.sv
module tb_msrv32_agu_pipe;

    typedef struct {
        logic [31:0] addr;
        logic        mis;
        logic        carry;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_vec;
    int   n_err;
    exp_t q[$];

    msrv32_agu_pipe_if #(.XLEN(32)) bus ();

    msrv32_agu_pipe #(.XLEN(32), .ALIGN_CHK(1'b1)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .flush_in             (flush),
        .agu                  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed directly from the operation definitions
    function automatic exp_t ref_f(input logic [1:0] m, input logic [1:0] s,
                                   input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm);
        exp_t        e;
        logic [63:0] sum;
        int unsigned align;
        case (m)
            2'b00:   sum = 64'(pc) + 64'(imm);
            2'b01:   sum = 64'(rs1) + 64'(imm);
            2'b10:   sum = 64'(rs1) + 64'(imm);
            default: sum = 64'(pc) + 64'd4;
        endcase
        e.carry = sum[32];
        e.addr  = sum[31:0];
        if (m == 2'b10) e.addr = e.addr & 32'hFFFF_FFFE;
        align = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        e.mis = ((e.addr % align) != 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid_out), 64'(q.size() > 0));
        chk({tag, ".ready"}, 64'(bus.in_ready_out), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, ".addr"},  64'(bus.iadder_out),   64'(q[0].addr));
            chk({tag, ".mis"},   64'(bus.misalign_out), 64'(q[0].mis));
            chk({tag, ".carry"}, 64'(bus.carry_out),    64'(q[0].carry));
        end
    endtask

    // Called 1 time unit after a rising edge. It drives one cycle and checks the result.
    task automatic step(input string tag, input bit v, input logic [1:0] m, input logic [1:0] s,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm,
                        input bit ordy, input bit fl);
        bit   acc;
        bit   pop;
        exp_t e;
        bus.in_valid_in  = v;
        bus.mode_in      = m;
        bus.size_in      = s;
        bus.pc_in        = pc;
        bus.rs1_in       = rs1;
        bus.imm_in       = imm;
        bus.out_ready_in = ordy;
        flush            = fl;
        acc = v && (q.size() < 2);
        pop = ordy && (q.size() > 0);
        e   = ref_f(m, s, pc, rs1, imm);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid_in  = 1'b0;
        bus.mode_in      = 2'b00;
        bus.size_in      = 2'b00;
        bus.pc_in        = 32'h0;
        bus.rs1_in       = 32'h0;
        bus.imm_in       = 32'h0;
        bus.out_ready_in = 1'b0;

        // 1 Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", 64'(bus.out_valid_out), 64'd0);
        chk("rst.ready", 64'(bus.in_ready_out), 64'd1);
        chk("rst.addr",  64'(bus.iadder_out), 64'd0);
        chk("rst.mis",   64'(bus.misalign_out), 64'd0);
        chk("rst.carry", 64'(bus.carry_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2 PC-relative with negative immediate
        step("t2", 1'b1, 2'b00, 2'b10, 32'h0000_1000, 32'h0, 32'hFFFF_FFF0, 1'b1, 1'b0);
        chk("t2.addr_const",  64'(bus.iadder_out), 64'h0000_0FF0);
        chk("t2.carry_const", 64'(bus.carry_out), 64'd1);

        // 3 JALR with LSB clear and a misaligned word access
        step("t3", 1'b1, 2'b10, 2'b10, 32'h0, 32'h0000_2003, 32'h0000_0004, 1'b1, 1'b0);
        chk("t3.addr_const", 64'(bus.iadder_out), 64'h0000_2006);
        chk("t3.mis_const",  64'(bus.misalign_out), 64'd1);
        step("t3.drain", 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 4 Back-to-back requests A, B, C while the consumer stalls, then drain in order
        step("t4.A", 1'b1, 2'b01, 2'b01, 32'h0, 32'h0000_0100, 32'h0000_0010, 1'b0, 1'b0);
        step("t4.B", 1'b1, 2'b01, 2'b00, 32'h0, 32'h0000_0200, 32'h0000_0021, 1'b0, 1'b0);
        step("t4.C", 1'b1, 2'b01, 2'b10, 32'h0, 32'h0000_0300, 32'h0000_0004, 1'b0, 1'b0);
        chk("t4.ready_full", 64'(bus.in_ready_out), 64'd0);
        chk("t4.head_A", 64'(bus.iadder_out), 64'h0000_0110);
        step("t4.popA", 1'b1, 2'b01, 2'b10, 32'h0, 32'h0000_0300, 32'h0000_0004, 1'b1, 1'b0);
        chk("t4.head_B", 64'(bus.iadder_out), 64'h0000_0221);
        step("t4.popB", 1'b1, 2'b01, 2'b10, 32'h0, 32'h0000_0300, 32'h0000_0004, 1'b1, 1'b0);
        chk("t4.head_C", 64'(bus.iadder_out), 64'h0000_0304);
        step("t4.popC", 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 5 Flush while full with a simultaneous request
        step("t5.f1", 1'b1, 2'b00, 2'b00, 32'h0000_4000, 32'h0, 32'h0000_0008, 1'b0, 1'b0);
        step("t5.f2", 1'b1, 2'b00, 2'b00, 32'h0000_5000, 32'h0, 32'h0000_0008, 1'b0, 1'b0);
        step("t5.flush", 1'b1, 2'b00, 2'b00, 32'h0000_6000, 32'h0, 32'h0000_0008, 1'b1, 1'b1);
        chk("t5.valid_const", 64'(bus.out_valid_out), 64'd0);
        step("t5.idle", 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 6 PC+4 wrap-around, then an asynchronous reset mid-stream
        step("t6", 1'b1, 2'b11, 2'b10, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        chk("t6.addr_const",  64'(bus.iadder_out), 64'h0);
        chk("t6.carry_const", 64'(bus.carry_out), 64'd1);
        step("t6.fill", 1'b1, 2'b01, 2'b01, 32'h0, 32'h0000_0011, 32'h0, 1'b0, 1'b0);
        bus.in_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("t6.rst_valid", 64'(bus.out_valid_out), 64'd0);
        chk("t6.rst_ready", 64'(bus.in_ready_out), 64'd1);
        @(posedge clk);
        #1;
        chk("t6.rst_hold", 64'(bus.out_valid_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
                 32'($urandom), 32'($urandom), 32'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
